// File: rtl/pc_call_sequencer_pkg.sv
// Shared definitions for the program-flow controller: opcode values,
// default widths, instruction field helpers and the controller state type.
package pc_call_sequencer_pkg;

  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int STACK_DEPTH_DEF = 8;
  localparam int INSTR_WIDTH     = 28;

  // Opcode field values (instruction[27:24]); only the flow opcodes are
  // decoded by the sequencer, the rest simply advance the IP.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_STO  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BLE  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_t;

  // Field slices of {op[27:24], dst[23:16], s1[15:8], s0[7:0]}
  function automatic logic [3:0] op_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[27:24];
  endfunction

  function automatic logic [7:0] dst_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[23:16];
  endfunction

  function automatic logic [7:0] s1_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[15:8];
  endfunction

  function automatic logic [7:0] s0_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[7:0];
  endfunction

endpackage

// File: rtl/pc_call_sequencer_call_stack.sv
// Return-address LIFO. The top entry is presented combinationally so a RET
// can load it into the IP in the same cycle it is decoded.
module pc_call_sequencer_call_stack
  import pc_call_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_WIDTH-1:0]          din,
  output logic [ADDR_WIDTH-1:0]          dout,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           full,
  output logic                           empty
);

  localparam int                 PTR_W     = $clog2(STACK_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]     DEPTH_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]     DEPTH_MAX = (PTR_W + 1)'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W:0]        depth_reg;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      top_ptr;

  // Depth is a power of two, so the low bits of the count index the array
  // and wrap naturally; the extra MSB distinguishes full from empty.
  assign wr_ptr  = depth_reg[PTR_W-1:0];
  assign top_ptr = wr_ptr - PTR_ONE;
  assign full    = (depth_reg == DEPTH_MAX);
  assign empty   = (depth_reg == '0);
  assign depth   = depth_reg;
  assign dout    = mem[top_ptr];

  // Storage write; contents are not reset, only the count is.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr] <= din;
    end
  end

  // Live-entry count; guarded so a misuse can never wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_reg <= '0;
    end else if (push && !full) begin
      depth_reg <= depth_reg + DEPTH_ONE;
    end else if (pop && !empty) begin
      depth_reg <= depth_reg - DEPTH_ONE;
    end
  end

endmodule

// File: rtl/pc_call_sequencer.sv
// Program-flow controller: drives the ROM address, decodes JMP/BLE/CALL/RET,
// and halts permanently on a return-stack overflow or underflow.
module pc_call_sequencer
  import pc_call_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INSTR_WIDTH-1:0]        instruction,
  input  logic                          branch_taken,
  input  logic                          stall,
  output logic [ADDR_WIDTH-1:0]         ip,
  output logic [$clog2(STACK_DEPTH):0]  stack_depth,
  output logic                          stack_overflow,
  output logic                          stack_underflow,
  output logic                          halted
);

  localparam logic [ADDR_WIDTH-1:0] IP_ONE = ADDR_WIDTH'(1);

  seq_state_t            state_reg;
  logic [ADDR_WIDTH-1:0] ip_reg;
  logic [ADDR_WIDTH-1:0] ip_next;
  logic [ADDR_WIDTH-1:0] ip_inc;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  push;
  logic                  pop;
  logic                  overflow_set;
  logic                  underflow_set;
  logic                  stack_full;
  logic                  stack_empty;
  logic [3:0]            op;
  logic                  unused_operands;

  // Source operands belong to the datapath; the sequencer never looks at them.
  assign unused_operands = ^{s1_of(instruction), s0_of(instruction)};

  assign op     = op_of(instruction);
  assign target = ADDR_WIDTH'(dst_of(instruction));
  // Modulo increment: all-ones wraps to zero, for both the next IP and the
  // return address pushed by CALL.
  assign ip_inc = ip_reg + IP_ONE;

  pc_call_sequencer_call_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ip_inc),
    .dout  (stack_top),
    .depth (stack_depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Next-IP mux and stack control; branch_taken is only consulted for BLE
  // so an undefined value elsewhere cannot reach the IP.
  always_comb begin
    ip_next       = ip_reg;
    push          = 1'b0;
    pop           = 1'b0;
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
    if (state_reg == ST_RUN && !stall) begin
      case (op)
        OP_JMP: ip_next = target;
        OP_BLE: ip_next = branch_taken ? target : ip_inc;
        OP_CALL: begin
          if (!stack_full) begin
            push    = 1'b1;
            ip_next = target;
          end else begin
            overflow_set = 1'b1;
          end
        end
        OP_RET: begin
          if (!stack_empty) begin
            pop     = 1'b1;
            ip_next = stack_top;
          end else begin
            underflow_set = 1'b1;
          end
        end
        default: ip_next = ip_inc;
      endcase
    end
  end

  // RUN/HALT state, IP register and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      ip_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      ip_reg <= ip_next;
      if (overflow_set) begin
        overflow_reg <= 1'b1;
        state_reg    <= ST_HALT;
      end
      if (underflow_set) begin
        underflow_reg <= 1'b1;
        state_reg     <= ST_HALT;
      end
    end
  end

  assign ip              = ip_reg;
  assign stack_overflow  = overflow_reg;
  assign stack_underflow = underflow_reg;
  assign halted          = (state_reg == ST_HALT);

endmodule

// File: tb/tb_pc_call_sequencer.sv
// Bench for pc_call_sequencer: table vectors for the straight-line flow,
// hand-written sequences with a reference model for stack corner cases, and
// a narrow instance for address wrap and a shallow stack.
module tb_pc_call_sequencer;
  import pc_call_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] instruction;
  logic        branch_taken;
  logic        stall;
  logic [15:0] ip;
  logic [3:0]  stack_depth;
  logic        stack_overflow, stack_underflow, halted;

  logic [27:0] instruction8;
  logic [7:0]  ip8;
  logic [1:0]  stack_depth8;
  logic        stack_overflow8, stack_underflow8, halted8;

  always #5 clk = ~clk;

  pc_call_sequencer #(.ADDR_WIDTH(16), .STACK_DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .branch_taken(branch_taken), .stall(stall), .ip(ip),
    .stack_depth(stack_depth), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow), .halted(halted)
  );

  pc_call_sequencer #(.ADDR_WIDTH(8), .STACK_DEPTH(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction8),
    .branch_taken(1'b0), .stall(1'b0), .ip(ip8),
    .stack_depth(stack_depth8), .stack_overflow(stack_overflow8),
    .stack_underflow(stack_underflow8), .halted(halted8)
  );

  typedef struct {
    logic [15:0] ip;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
    logic        halt;
  } exp_t;

  typedef struct {
    logic [27:0] instr;
    logic        bt;
    logic        stall;
    exp_t        exp;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  // Reference model state
  logic [15:0] m_ip;
  logic [15:0] m_stk[$];
  logic        m_ovf, m_unf, m_halt;

  function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] dst);
    return {op, dst, 16'h0000};
  endfunction

  function automatic exp_t ex(input logic [15:0] e_ip, input logic [3:0] e_depth);
    exp_t e;
    e.ip = e_ip; e.depth = e_depth; e.ovf = 1'b0; e.unf = 1'b0; e.halt = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_ip = 16'h0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic [27:0] instr, input logic bt, input logic st,
                            output exp_t e);
    logic [7:0] d;
    d = instr[23:16];
    if (!m_halt && !st) begin
      case (instr[27:24])
        OP_JMP: m_ip = {8'h00, d};
        OP_BLE: m_ip = bt ? {8'h00, d} : m_ip + 16'd1;
        OP_CALL: begin
          if (m_stk.size() < 8) begin
            m_stk.push_back(m_ip + 16'd1);
            m_ip = {8'h00, d};
          end else begin
            m_ovf = 1'b1; m_halt = 1'b1;
          end
        end
        OP_RET: begin
          if (m_stk.size() > 0) m_ip = m_stk.pop_back();
          else begin
            m_unf = 1'b1; m_halt = 1'b1;
          end
        end
        default: m_ip = m_ip + 16'd1;
      endcase
    end
    e.ip = m_ip; e.depth = 4'(m_stk.size());
    e.ovf = m_ovf; e.unf = m_unf; e.halt = m_halt;
  endtask

  // Drive one instruction, queue its expectation, compare after the edge.
  task automatic apply(input string tag, input logic [27:0] instr, input logic bt,
                       input logic st, input exp_t e);
    exp_t got;
    instruction = instr; branch_taken = bt; stall = st;
    exp_q.push_back(e);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    txn++;
    $display("txn %0d %s op=%0h dst=%0d stall=%0b ip=%0h depth=%0d ovf=%0b unf=%0b halt=%0b",
             txn, tag, instr[27:24], instr[23:16], st, ip, stack_depth,
             stack_overflow, stack_underflow, halted);
    chk({tag, "_ip"},    32'(ip),              32'(got.ip));
    chk({tag, "_depth"}, 32'(stack_depth),     32'(got.depth));
    chk({tag, "_ovf"},   32'(stack_overflow),  32'(got.ovf));
    chk({tag, "_unf"},   32'(stack_underflow), 32'(got.unf));
    chk({tag, "_halt"},  32'(halted),          32'(got.halt));
  endtask

  task automatic run_model(input string tag, input logic [27:0] instr, input logic bt,
                           input logic st);
    exp_t e;
    model_step(instr, bt, st, e);
    apply(tag, instr, bt, st, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instruction = mk(OP_NOP, 8'h00); branch_taken = 1'b0; stall = 1'b0;
    instruction8 = mk(OP_NOP, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step8(input string tag, input logic [27:0] instr,
                       input logic [7:0] e_ip, input logic [1:0] e_depth);
    instruction8 = instr;
    @(posedge clk); #1;
    txn++;
    $display("txn %0d %s op=%0h dst=%0d ip8=%0h depth8=%0d ovf8=%0b halt8=%0b",
             txn, tag, instr[27:24], instr[23:16], ip8, stack_depth8,
             stack_overflow8, halted8);
    chk({tag, "_ip"},    32'(ip8),          32'(e_ip));
    chk({tag, "_depth"}, 32'(stack_depth8), 32'(e_depth));
  endtask

  vec_t tbl[16];

  initial begin
    instruction = 28'h0; branch_taken = 1'b0; stall = 1'b0; instruction8 = 28'h0;
    model_reset();

    // Straight-line flow, CALL/RET round trip, BLE both ways, stall hold
    tbl[0]  = '{mk(OP_STO, 8'd0),  1'bx, 1'b0, ex(16'd1, 4'd0)};
    tbl[1]  = '{mk(OP_STO, 8'd0),  1'bx, 1'b0, ex(16'd2, 4'd0)};
    tbl[2]  = '{mk(OP_STO, 8'd0),  1'bx, 1'b0, ex(16'd3, 4'd0)};
    tbl[3]  = '{mk(OP_STO, 8'd0),  1'bx, 1'b0, ex(16'd4, 4'd0)};
    tbl[4]  = '{mk(OP_CALL, 8'd7), 1'bx, 1'b0, ex(16'd7, 4'd1)};
    tbl[5]  = '{mk(OP_SHL, 8'd0),  1'bx, 1'b0, ex(16'd8, 4'd1)};
    tbl[6]  = '{mk(OP_RET, 8'd0),  1'bx, 1'b0, ex(16'd5, 4'd0)};
    tbl[7]  = '{mk(OP_ADD, 8'd0),  1'bx, 1'b0, ex(16'd6, 4'd0)};
    tbl[8]  = '{mk(OP_JMP, 8'd9),  1'bx, 1'b0, ex(16'd9, 4'd0)};
    tbl[9]  = '{mk(OP_ADD, 8'd0),  1'bx, 1'b0, ex(16'd10, 4'd0)};
    tbl[10] = '{mk(OP_NOP, 8'd0),  1'bx, 1'b0, ex(16'd11, 4'd0)};
    tbl[11] = '{mk(OP_BLE, 8'd10), 1'b1, 1'b0, ex(16'd10, 4'd0)};
    tbl[12] = '{mk(OP_NOP, 8'd0),  1'bx, 1'b0, ex(16'd11, 4'd0)};
    tbl[13] = '{mk(OP_BLE, 8'd10), 1'b0, 1'b0, ex(16'd12, 4'd0)};
    tbl[14] = '{mk(OP_JMP, 8'd3),  1'bx, 1'b1, ex(16'd12, 4'd0)};
    tbl[15] = '{mk(OP_BLE, 8'd3),  1'b1, 1'b1, ex(16'd12, 4'd0)};

    // Reset asserted mid-run takes effect without a clock edge
    do_reset();
    for (int i = 0; i < 5; i++) run_model("pre_reset", {OP_NOP, 24'($urandom)}, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_ip",    32'(ip), 32'd0);
    chk("async_reset_depth", 32'(stack_depth), 32'd0);
    chk("async_reset_ovf",   32'(stack_overflow), 32'd0);
    chk("async_reset_unf",   32'(stack_underflow), 32'd0);
    chk("async_reset_halt",  32'(halted), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].instr, tbl[i].bt, tbl[i].stall, tbl[i].exp);
    end

    // Nested CALLs fill the stack; the ninth overflows and halts
    do_reset();
    for (int i = 0; i < 8; i++) run_model("call_fill", mk(OP_CALL, 8'(i + 1)), 1'b0, 1'b0);
    run_model("call_ovf", mk(OP_CALL, 8'd9), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      run_model("halt_ovf", 28'($urandom), 1'($urandom), 1'($urandom));
    chk("ovf_ip_frozen", 32'(ip), 32'd8);
    chk("ovf_depth",     32'(stack_depth), 32'd8);
    chk("ovf_no_unf",    32'(stack_underflow), 32'd0);

    // Return addresses come back in LIFO order
    do_reset();
    run_model("lifo_call", mk(OP_CALL, 8'd10), 1'b0, 1'b0);
    run_model("lifo_call", mk(OP_CALL, 8'd20), 1'b0, 1'b0);
    run_model("lifo_call", mk(OP_CALL, 8'd30), 1'b0, 1'b0);
    run_model("lifo_ret",  mk(OP_RET, 8'd0), 1'b0, 1'b0);
    run_model("lifo_ret",  mk(OP_RET, 8'd0), 1'b0, 1'b0);
    run_model("lifo_ret",  mk(OP_RET, 8'd0), 1'b0, 1'b0);
    chk("lifo_final_ip", 32'(ip), 32'd1);

    // RET on an empty stack underflows and halts
    do_reset();
    run_model("ret_unf", mk(OP_RET, 8'd0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_model("halt_unf", 28'($urandom), 1'($urandom), 1'($urandom));
    chk("unf_flag", 32'(stack_underflow), 32'd1);
    chk("unf_no_ovf", 32'(stack_overflow), 32'd0);

    // Stalled CALL takes effect exactly once on release
    do_reset();
    for (int i = 0; i < 4; i++) run_model("to4", mk(OP_NOP, 8'd0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_model("call_stall", mk(OP_CALL, 8'd50), 1'b0, 1'b1);
    run_model("call_release", mk(OP_CALL, 8'd50), 1'b0, 1'b0);
    run_model("after_call", mk(OP_NOP, 8'd0), 1'b0, 1'b0);
    chk("stall_call_ip", 32'(ip), 32'd51);
    chk("stall_call_depth", 32'(stack_depth), 32'd1);

    // Reset during an in-flight CALL discards the push
    do_reset();
    instruction = mk(OP_CALL, 8'd40);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_call_ip", 32'(ip), 32'd0);
    chk("reset_mid_call_depth", 32'(stack_depth), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Narrow instance: IP and return-address wrap, shallow stack overflow
    do_reset();
    step8("w_jmp",   mk(OP_JMP, 8'd255), 8'd255, 2'd0);
    step8("w_nop",   mk(OP_NOP, 8'd0),   8'd0,   2'd0);
    step8("w_jmp2",  mk(OP_JMP, 8'd255), 8'd255, 2'd0);
    step8("w_call",  mk(OP_CALL, 8'd3),  8'd3,   2'd1);
    step8("w_ret",   mk(OP_RET, 8'd0),   8'd0,   2'd0);
    step8("w_nop2",  mk(OP_NOP, 8'd0),   8'd1,   2'd0);
    step8("s_call1", mk(OP_CALL, 8'd9),  8'd9,   2'd1);
    step8("s_call2", mk(OP_CALL, 8'd9),  8'd9,   2'd2);
    step8("s_call3", mk(OP_CALL, 8'd20), 8'd9,   2'd2);
    chk("w_ovf8",  32'(stack_overflow8), 32'd1);
    chk("w_halt8", 32'(halted8), 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
